// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: correction-bus width, field offsets
// and a typed view of one correction.
package bp_pkg;

  localparam int CORR_BUS_W = 104;
  localparam int CORR_DEPTH = 4;

  localparam int VALID_B     = 0;
  localparam int BRANCH_B    = 1;
  localparam int INST_LSB    = 2;
  localparam int INST_MSB    = 33;
  localparam int BRA_LSB     = 34;
  localparam int BRA_MSB     = 65;
  localparam int UNCOND_B    = 66;
  localparam int LINK_B      = 67;
  localparam int RET_B       = 68;
  localparam int PHT_B       = 69;
  localparam int BHT_B       = 70;
  localparam int FLUSH_V_B   = 71;
  localparam int FLUSH_LSB   = 72;
  localparam int FLUSH_MSB   = 103;

  // Packed MSB-first so it overlays the bus bit offsets above exactly.
  typedef struct packed {
    logic [31:0] flush_addr;
    logic        flush_valid;
    logic        bht;
    logic        pht;
    logic        ret;
    logic        link;
    logic        uncond;
    logic [31:0] branch_addr;
    logic [31:0] inst_addr;
    logic        branch_flag;
    logic        valid;
  } corr_t;

endpackage

// File: rtl/bp_corr_arbiter_if.sv
// Dual-slot resolve-side handshake into the correction arbiter.
interface bp_corr_arbiter_if #(
  parameter int BUS_W = bp_pkg::CORR_BUS_W
);
  logic [BUS_W-1:0] corr_bus0_i;
  logic [BUS_W-1:0] corr_bus1_i;
  logic             in_ready_o;

  modport master (output corr_bus0_i, output corr_bus1_i, input  in_ready_o);
  modport slave  (input  corr_bus0_i, input  corr_bus1_i, output in_ready_o);
endinterface

// File: rtl/bp_corr_fifo.sv
// Dual-push / single-pop in-order FIFO. Also exposes the entry that will sit
// at head after this edge so the caller can register it without a bypass mux.
module bp_corr_fifo import bp_pkg::*; #(
  parameter int DEPTH = CORR_DEPTH,
  parameter int BUS_W = CORR_BUS_W,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push0,
  input  logic             push1,
  input  logic [BUS_W-1:0] din0,
  input  logic [BUS_W-1:0] din1,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_nxt,
  output logic [BUS_W-1:0] head_nxt_data
);
  localparam int PW = $clog2(DEPTH);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail, head_nxt, tail1;
  logic [1:0]       npush;
  logic [BUS_W-1:0] w0;

  always_comb begin
    npush     = {1'b0, push0} + {1'b0, push1};
    // A lone slot-1 push still lands at tail to keep the queue dense.
    w0        = push0 ? din0 : din1;
    tail1     = tail + PW'(1);
    head_nxt  = head + PW'(pop);
    count_nxt = flush ? '0 : count + CW'(npush) - CW'(pop);
    // If nothing older survives the pop, next head is the first word written now.
    head_nxt_data = (count == CW'(pop)) ? w0 : mem[head_nxt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail + PW'(npush);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && npush != 2'd0) mem[tail]  <= w0;
    if (!flush && npush == 2'd2) mem[tail1] <= din1;
  end

endmodule

// File: rtl/bp_corr_arbiter.sv
// Branch-correction scheduler: queues up to two resolve-slot corrections per
// cycle and feeds the predictor one registered correction per cycle.
module bp_corr_arbiter import bp_pkg::*; #(
  parameter int DEPTH = CORR_DEPTH,
  parameter int BUS_W = CORR_BUS_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  bp_corr_arbiter_if.slave           req,
  output logic [BUS_W-1:0]           corr_branch_bus_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o
);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]    count, count_nxt;
  logic [BUS_W-1:0] head_nxt_data;
  logic             ready, push0, push1, pop;

  // Ready ignores the same-cycle drain so two free slots are always real.
  assign ready = (count <= CW'(DEPTH-2));
  assign push0 = req.corr_bus0_i[VALID_B] & ready & ~flush_i;
  assign push1 = req.corr_bus1_i[VALID_B] & ready & ~flush_i;
  assign pop   = (count != '0) & ~flush_i;

  assign req.in_ready_o = ready;
  assign pending_o      = count;

  bp_corr_fifo #(.DEPTH(DEPTH), .BUS_W(BUS_W), .CW(CW)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush_i),
    .push0         (push0),
    .push1         (push1),
    .din0          (req.corr_bus0_i),
    .din1          (req.corr_bus1_i),
    .pop           (pop),
    .count         (count),
    .count_nxt     (count_nxt),
    .head_nxt_data (head_nxt_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   corr_branch_bus_o <= '0;
    else if (count_nxt != '0)   corr_branch_bus_o <= head_nxt_data | BUS_W'(1);
    else                        corr_branch_bus_o <= '0;
  end

endmodule

// File: doc/bp_corr_arbiter.md
# bp_corr_arbiter

Branch-correction scheduler between the two ID-stage resolve slots and the predictor's single correction port. Both issue slots can resolve a branch in the same cycle. The predictor accepts one correction per cycle. This block queues up to two corrections per cycle in a small in-order FIFO and drains one per cycle onto the predictor correction bus. On an exception/branch flush it discards queued wrong-path corrections.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- BUS_W, 104, correction-bus width (bit 0 = valid; field layout per shared package)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- flush_i  input  1  exception or branch flush; synchronous clear of queue
- corr_bus0_i  input  BUS_W  correction from slot 0 (older); bit 0 = request valid
- corr_bus1_i  input  BUS_W  correction from slot 1 (younger); bit 0 = request valid
- in_ready_o  output  1  both slots may push this cycle
- corr_branch_bus_o  output  BUS_W  to predictor correction port; bit 0 = valid
- pending_o  output  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage:
  - DEPTH × BUS_W entry array.
  - Head and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register.
- Ready: in_ready_o = (count ≤ DEPTH−2).
  - Computed from the registered count only; the same-cycle drain is not credited.
  - Two free slots are therefore always guaranteed.
- Push: a slot pushes when its bus bit 0 = 1, in_ready_o = 1 and flush_i = 0.
  - Slot 0 only: written at tail.
  - Slot 1 only: written at tail.
  - Both slots: slot 0 at tail, slot 1 at tail+1 (order preserved).
  - tail advances by the number of pushes.
- Upstream hold rule: when in_ready_o = 0, upstream holds its buses. The block never drops a push attempted while ready.
- Pop: one entry per cycle whenever count ≠ 0 and flush_i = 0. head advances by 1.
- Output register corr_branch_bus_o:
  - When count_next ≠ 0, it loads the entry that will be at head next cycle, with bit 0 forced to 1.
  - Otherwise it loads all zeros.
  - It always equals the current head entry, or zero when empty.
- Count: count_next = count + pushes − pop. Pushes range 0..2, pop 0..1. Count never exceeds DEPTH.
- Simultaneous push and pop:
  - Both take effect in the same cycle.
  - When empty, a pushed entry is not visible until the next cycle; there is no bypass.
- Flush: flush_i = 1 sets head = tail = 0, count = 0 and output to 0 on the next edge.
  - Same-cycle pushes are dropped.
  - Same-cycle pop is suppressed.
  - Flush overrides everything except reset.
- Reset (async, any time including mid-drain):
  - head, tail and count = 0.
  - corr_branch_bus_o = 0.
  - in_ready_o = 1.
  - pending_o = 0.
  - Array contents are don't-care.

## Timing
- Latency: push at edge N → entry on corr_branch_bus_o from cycle N+1, provided it is head.
- Throughput: 1 correction out per cycle sustained; burst of 2 in per cycle.
- in_ready_o and pending_o are purely registered-state functions; there is no combinational path from inputs.
- corr_branch_bus_o is registered. The predictor samples it at edge N+1 as a correction for that cycle.
- Ordering is strict program order: slot 0 before slot 1, then cycle order.

## Structure
- Shared package bp_pkg holds:
  - BUS_W.
  - Correction-bus field offsets: valid 0, branch_flag 1, inst_addr 33:2, branch_addr 65:34, uncond 66, link 67, return 68, pht 69, bht 70, fllush_valid 71, fllush_addr 103:72.
  - Default DEPTH.
- One sub-module is natural: bp_corr_fifo.
  - Dual-push/single-pop FIFO containing the array, pointers and count.
  - The top level adds the ready policy, flush gating and output register.

## Test plan
- Reset release, no requests → corr_branch_bus_o = 0, pending_o = 0, in_ready_o = 1 for 10 cycles.
- Slot 0 only, inst_addr 0x1000, at cycle 5 → output bit 0 = 1, inst_addr 0x1000 in cycle 6; output 0 in cycle 7.
- Both slots every cycle for 4 cycles, addresses 0x100/0x104, 0x108/0x10C, … → in_ready_o drops once pending_o ≥ 3. Outputs appear in order 0x100, 0x104, 0x108… with none lost or duplicated. Pending never exceeds 4.
- Queue holds 3 entries, flush_i pulsed together with a slot-0 push → next cycle pending_o = 0, output 0, and the pushed entry is never emitted.
- rst asserted asynchronously mid-cycle with 2 entries pending → output, pending_o and pointers clear immediately. After release, new pushes start at entry 0 and drain correctly.
- Pointer wrap: 9 single pushes spaced so the queue drains continuously → all 9 emitted in order across two pointer wraps.
